// File: rtl/light_pattern_sequencer.sv
// Walks the pattern memory entry by entry, holding each entry for its programmed
// duration and driving one PWM output per light from the entry's brightness nibbles.
module light_pattern_sequencer #(
  parameter  int unsigned NUM_ENTRIES = 8,
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned NUM_LIGHTS  = 4,
  parameter  int unsigned TICK_DIV    = 16,
  localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enable,
  output logic                  mem_rd_en,
  output logic [IDX_W-1:0]      mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [NUM_LIGHTS-1:0] lights_out,
  output logic [IDX_W-1:0]      active_idx,
  output logic                  busy,
  output logic                  wrap_pulse
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DUR_W = 16;
  localparam int unsigned LVL_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_RUN} state_t;

  state_t                           r_state;
  logic [IDX_W-1:0]                 r_idx;
  logic [PRE_W-1:0]                 r_pre;
  logic [DUR_W-1:0]                 r_tick;
  logic [DUR_W-1:0]                 r_dur;
  logic [LVL_W-1:0]                 r_pwm;
  logic [NUM_LIGHTS-1:0][LVL_W-1:0] r_level;
  logic                             r_blocked;
  logic                             r_mem_rd_en;
  logic [IDX_W-1:0]                 r_mem_rd_addr;
  logic [NUM_LIGHTS-1:0]            r_lights;
  logic [IDX_W-1:0]                 r_active;
  logic                             r_busy;
  logic                             r_wrap;

  logic [DUR_W-1:0]                 w_dur;
  logic [IDX_W-1:0]                 w_idx_inc;
  logic [NUM_LIGHTS-1:0]            w_pwm_cmp;

  assign w_dur     = mem_rd_data[DATA_WIDTH-1 -: DUR_W];
  assign w_idx_inc = r_idx + IDX_W'(1);

  // Per-light PWM comparison against the free-running counter
  always_comb begin
    w_pwm_cmp = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      w_pwm_cmp[i] = (r_level[i] > r_pwm);
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_pre         <= '0;
      r_tick        <= '0;
      r_dur         <= '0;
      r_pwm         <= '0;
      r_level       <= '0;
      r_blocked     <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_lights      <= '0;
      r_active      <= '0;
      r_busy        <= 1'b0;
      r_wrap        <= 1'b0;
    end else begin
      r_pwm       <= r_pwm + LVL_W'(1);
      r_wrap      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_lights    <= w_pwm_cmp;
      if (!enable) begin
        // Stop clears the re-arm block so the next enable restarts from entry 0
        r_state   <= S_IDLE;
        r_idx     <= '0;
        r_level   <= '0;
        r_lights  <= '0;
        r_active  <= '0;
        r_busy    <= 1'b0;
        r_blocked <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_lights <= '0;
            if (!r_blocked) begin
              r_state       <= S_FETCH;
              r_mem_rd_en   <= 1'b1;
              r_mem_rd_addr <= r_idx;
              r_busy        <= 1'b1;
            end
          end
          S_FETCH: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (w_dur != '0) begin
              r_level  <= mem_rd_data[NUM_LIGHTS*LVL_W-1:0];
              r_active <= r_idx;
              r_pre    <= '0;
              r_tick   <= '0;
              r_dur    <= w_dur;
              r_state  <= S_RUN;
            end else if (r_idx != '0) begin
              r_idx         <= '0;
              r_wrap        <= 1'b1;
              r_state       <= S_FETCH;
              r_mem_rd_en   <= 1'b1;
              r_mem_rd_addr <= '0;
            end else begin
              // Empty pattern: park until enable is cycled
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_level   <= '0;
              r_lights  <= '0;
              r_active  <= '0;
              r_blocked <= 1'b1;
            end
          end
          S_RUN: begin
            if (r_pre == PRE_W'(TICK_DIV - 1)) begin
              r_pre <= '0;
              if (r_tick == r_dur - DUR_W'(1)) begin
                r_idx         <= w_idx_inc;
                r_wrap        <= (r_idx == IDX_W'(NUM_ENTRIES - 1));
                r_state       <= S_FETCH;
                r_mem_rd_en   <= 1'b1;
                r_mem_rd_addr <= w_idx_inc;
              end else begin
                r_tick <= r_tick + DUR_W'(1);
              end
            end else begin
              r_pre <= r_pre + PRE_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign lights_out  = r_lights;
  assign active_idx  = r_active;
  assign busy        = r_busy;
  assign wrap_pulse  = r_wrap;

endmodule
